// File: rtl/sm_hex_display.sv
// Multiplexed common-anode 7-segment hex display driver: one digit per refresh slot,
// anode blanking at the start of each slot, and optional leading-zero suppression.
module sm_hex_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       number,
  input  logic              load,
  input  logic              blankEn,
  output logic [DIGITS-1:0] anodes,
  output logic [6:0]        segments
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ShW  = 4 * DIGITS;

  logic [ShW-1:0]    shadow_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]        segs_q, segs_d;

  logic       cnt_wrap;
  logic       upper_zero;
  logic       blank;
  logic [3:0] cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_wrap = (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the active nibble and check whether it and every higher nibble are zero.
  always_comb begin
    cur_nib    = 4'h0;
    upper_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = shadow_q[4*i +: 4];
      end
      if ((IdxW'(i) >= idx_q) && (shadow_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  always_comb begin
    blank = (cnt_q < CntW'(BLANK_CYCLES)) ||
            (blankEn && (idx_q != '0) && upper_zero);
    anodes_d = '1;
    segs_d   = 7'b1111111;
    if (!blank) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_q == IdxW'(i)) begin
          anodes_d[i] = 1'b0;
        end
      end
      segs_d = hex7(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      anodes_q <= '1;
      segs_q   <= 7'b1111111;
    end else begin
      if (load) begin
        shadow_q <= number[ShW-1:0];
      end
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      segs_q   <= segs_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segs_q;

endmodule

// File: tb/tb_sm_hex_display.sv
// Bench for sm_hex_display: directed scenarios then random traffic, each cycle compared
// against a cycle-count based model of the scan.
module tb_sm_hex_display;

  localparam int unsigned D = 8;
  localparam int unsigned R = 4;
  localparam int unsigned B = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  number = '0;
  logic         load = 1'b0;
  logic         blank_en = 1'b0;
  logic [D-1:0] anodes;
  logic [6:0]   segments;

  sm_hex_display #(
    .DIGITS      (D),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .number  (number),
    .load    (load),
    .blankEn (blank_en),
    .anodes  (anodes),
    .segments(segments)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: edges since the last reset edge, and the displayed value.
  int          m_cycle = 0;
  logic [31:0] m_shadow = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_cycle);
  endtask

  // One clock: apply inputs, predict, clock, compare, advance the model.
  task automatic tick(input logic r, input logic ld, input logic [31:0] num, input logic be);
    logic [D-1:0] exp_an;
    logic [6:0]   exp_sg;
    int           slot_cnt, digit;
    logic         blank;
    rst = r; load = ld; number = num; blank_en = be;
    slot_cnt = m_cycle % R;
    digit    = (m_cycle / R) % D;
    blank    = (slot_cnt < B) || (be && digit > 0 && (m_shadow >> (4 * digit)) == 0);
    if (r || blank) begin
      exp_an = '1;
      exp_sg = 7'b1111111;
    end else begin
      exp_an = ~(D'(1) << digit);
      exp_sg = hex_tab[(m_shadow >> (4 * digit)) & 32'hF];
    end
    @(posedge clk);
    #1;
    check("anodes", 32'(anodes), 32'(exp_an));
    check("segments", 32'(segments), 32'(exp_sg));
    check("one_hot_anode", 32'($countones(~anodes) <= 1), 32'd1);
    if (r) begin
      m_cycle  = 0;
      m_shadow = '0;
    end else begin
      if (ld) m_shadow = num;
      m_cycle++;
    end
  endtask

  task automatic run(input int n, input logic be);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom, be);
  endtask

  initial begin
    // Reset, then the first slot: blank at cnt 0, digit 0 shows "0".
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    check("reset_anodes", 32'(anodes), 32'hFF);
    check("reset_segments", 32'(segments), 32'h7F);
    tick(1'b0, 1'b0, '0, 1'b0);
    check("first_slot_blank", 32'(anodes), 32'hFF);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b0);
    check("digit0_zero", 32'(segments), 32'b1000000);

    // Full scan of a mixed value.
    tick(1'b0, 1'b1, 32'h89AB_CDEF, 1'b0);
    run(32, 1'b0);

    // Leading-zero suppression on and off.
    tick(1'b0, 1'b1, 32'h0000_00A5, 1'b1);
    run(32, 1'b1);
    run(32, 1'b0);
    tick(1'b0, 1'b1, 32'h0, 1'b1);
    run(32, 1'b1);

    // Mid-slot load: segments follow one cycle after the load edge.
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 32'h1, 1'b0);
    tick(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    check("mid_slot_load", 32'(segments), 32'b1111001);
    run(30, 1'b0);

    // Reset in the middle of digit 5's slot.
    while (((m_cycle / R) % D) != 5 || (m_cycle % R) != 2) tick(1'b0, 1'b0, $urandom, 1'b0);
    tick(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    check("midscan_reset_blank", 32'(anodes), 32'hFF);
    tick(1'b0, 1'b0, 32'h1234_5678, 1'b0);
    tick(1'b0, 1'b0, 32'h1234_5678, 1'b0);
    check("restart_digit0", 32'(anodes), 32'hFE);
    check("restart_shadow0", 32'(segments), 32'b1000000);
    run(8, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 1) == 0) v = v >> (4 * $urandom_range(0, 7));
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), v,
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
